// File: rtl/md_pkg.sv
// Shared opcode encodings, FSM states and op-class predicates for the mult/div unit.
// MD_HILO_MADD_EN adds madd/maddu/msub/msubu to the multiply class.
package md_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_mul_class(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MD_HILO_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    logic r;
    case (op)
      OP_DIV, OP_DIVU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit mult/div result generator; returns {hi, lo}.
// With MD_HILO_MADD_EN the accumulate ops fold in the current {HI,LO}.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MD_HILO_MADD_EN
  input  logic [31:0] hi,
  input  logic [31:0] lo,
`endif
  output logic [63:0] res
);

  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;

  assign prod_s_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u_s = {32'd0, a} * {32'd0, b};

  // Result select; zero-divisor and signed-overflow cases are resolved before dividing
  always_comb begin
    res = 64'd0;
    case (op)
      OP_MULT:  res = prod_s_s;
      OP_MULTU: res = prod_u_s;
      OP_DIV: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          res = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          res = {a % b, a / b};
        end
      end
`ifdef MD_HILO_MADD_EN
      OP_MADD:  res = {hi, lo} + prod_s_s;
      OP_MADDU: res = {hi, lo} + prod_u_s;
      OP_MSUB:  res = {hi, lo} - prod_s_s;
      OP_MSUBU: res = {hi, lo} - prod_u_s;
`endif
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_hilo_unit.sv
// E-stage multiply/divide unit: latency FSM, HI/LO registers, mthi/mtlo/mfhi/mflo.
// Optional accumulate ops are enabled by MD_HILO_MADD_EN.
module md_hilo_unit
  import md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  HILO_Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HILO_rd
);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] hi_r, hi_s, lo_r, lo_s;
  logic [31:0] pend_hi_r, pend_hi_s, pend_lo_r, pend_lo_s;
  logic [63:0] res_s;

  md_arith u_arith (
    .op  (HILO_Op),
    .a   (A),
    .b   (B),
`ifdef MD_HILO_MADD_EN
    .hi  (hi_r),
    .lo  (lo_r),
`endif
    .res (res_s)
  );

  // State, counter, pending-result and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
      pend_hi_r <= pend_hi_s;
      pend_lo_r <= pend_lo_s;
    end
  end

  // Next-state logic: launch, count down, commit; moves to HI/LO only when idle
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    hi_s      = hi_r;
    lo_s      = lo_r;
    pend_hi_s = pend_hi_r;
    pend_lo_s = pend_lo_r;
    case (state_r)
      ST_IDLE: begin
        if (start && is_mul_class(HILO_Op)) begin
          state_s   = ST_RUN;
          cnt_s     = 4'(MULT_LAT);
          pend_hi_s = res_s[63:32];
          pend_lo_s = res_s[31:0];
        end else if (start && is_div_class(HILO_Op)) begin
          state_s   = ST_RUN;
          cnt_s     = 4'(DIV_LAT);
          pend_hi_s = res_s[63:32];
          pend_lo_s = res_s[31:0];
        end else if (HILO_Op == OP_MTHI) begin
          hi_s = A;
        end else if (HILO_Op == OP_MTLO) begin
          lo_s = A;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == 4'd1) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
          hi_s    = pend_hi_r;
          lo_s    = pend_lo_r;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // mfhi/mflo read port; other codes read as zero
  always_comb begin
    HILO_rd = 32'd0;
    case (HILO_Op)
      OP_MFHI: HILO_rd = hi_r;
      OP_MFLO: HILO_rd = lo_r;
      default: HILO_rd = 32'd0;
    endcase
  end

  assign busy = (state_r == ST_RUN);
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: doc/md_hilo_unit.md
Name: md_hilo_unit

Overview:
- Multiply/divide execution unit for the pipelined MIPS core; sits in the E stage beside the ALU.
- Sequences multi-cycle mult/div operations and owns the HI/LO registers.
- Serves mthi/mtlo writes and mfhi/mflo reads.
- Publishes `busy` so the D-stage stall logic holds HI/LO-dependent instructions. The stall logic uses `start` OR `busy` as its hazard term.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (and madd-family when enabled); legal range 1..15.
- DIV_LAT, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  E-stage instruction is a mult/div-class op; qualifies `HILO_Op`.
- HILO_Op  in  4  operation code, encodings from the shared package.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- busy  out  1  a multi-cycle operation is in flight.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.
- HILO_rd  out  32  mfhi→HI, mflo→LO, any other op→0; combinational.

Behaviour:
- Reset: state=IDLE, counter=0, HI=0, LO=0, busy=0, pending result regs=0. Reset mid-operation aborts the operation; HI/LO do not take the pending result.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1. Counter loads the latency; pending HI/LO hold the result latched at start.
- IDLE→RUN on a clk edge with start=1 and a mult-class or div-class op. A and B are sampled on that edge, the result is computed combinationally and latched into pending regs, and the counter loads MULT_LAT or DIV_LAT.
- RUN: the counter decrements every cycle. At the edge where counter==1: HI/LO←pending, state→IDLE, counter→0.
- Timing: start in cycle t → busy high for cycles t+1..t+LAT. The new HI/LO values are visible from cycle t+LAT+1, and busy is 0 in that cycle.
- start while busy: ignored, no state change. The stall unit makes this illegal; the bench asserts it never happens.
- mthi/mtlo: single-cycle; HI or LO ← A at the edge. No start is required. Ignored while busy. Simultaneous start + mthi is impossible (single op code).
- mfhi/mflo: purely combinational read of the current HI/LO. During busy, the old values are returned (the stall unit prevents consumption).
- Arithmetic:
  - mult: signed 64-bit product; HI=[63:32], LO=[31:0].
  - multu: unsigned 64-bit product.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div/divu by zero: LO=32'hFFFF_FFFF, HI=A.
  - div overflow (0x8000_0000 / -1): LO=0x8000_0000, HI=0.
- All other op codes: no effect.

Optional Feature:
- Macro: MD_HILO_MADD_EN.
- Defined: madd, maddu, msub, msubu are accepted as mult-class ops (MULT_LAT). Pending result = {HI,LO} ± product, 64-bit wrap. The signed or unsigned product is taken per opcode. {HI,LO} is sampled at start.
- Undefined: those encodings are treated as no-op, with busy never asserted.

Decomposition:
- Shared package md_pkg holds:
  - HILO_Op localparams: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - FSM state encodings.
  - Helper predicates is_mul_class and is_div_class.
- One natural sub-module: md_arith, the combinational 64-bit result generator (op, A, B, HI, LO → {hi,lo}), including the div-by-zero and overflow rules. md_hilo_unit keeps the FSM, counter and registers.

Test Plan:
- Reset mid-div: start DIV A=100 B=7, assert reset at cycle t+4 → busy=0 immediately, HI=0, LO=0, no later update.
- MULT A=0xFFFF_FFFF (-1) B=2 at cycle t → busy=1 for cycles t+1..t+5; at t+6 HI=0xFFFF_FFFF, LO=0xFFFF_FFFE, busy=0.
- MULTU with the same operands → HI=0x0000_0001, LO=0xFFFF_FFFE after 5 busy cycles.
- DIV A=-7 B=2 → after 10 busy cycles LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). Then DIVU A=5 B=0 → LO=0xFFFF_FFFF, HI=5.
- MTHI A=0x1234 then MFLO/MFHI reads → HI=0x1234 next cycle, HILO_rd=0x1234 on MFHI. MTLO issued while busy → LO unchanged.
- DIV A=0x8000_0000 B=0xFFFF_FFFF → LO=0x8000_0000, HI=0. With MD_HILO_MADD_EN: HI=0, LO=0xFFFF_FFFF, MADDU A=1 B=1 → HI=1, LO=0 after 5 cycles.
